seq_subtractor: RTL and testbench
=================================

Name: seq_subtractor

Overview:
- Multi-cycle, chunk-serial two's-complement subtractor: computes DIFF = A - B - BIN. It is the inverse-direction companion to the combinational carry-lookahead adder in the arithmetic datapath.
- Processes CHUNK bits per cycle, propagating an internal borrow between chunks. This trades latency for area in the FPU/ALU exploration units.
- Uses a START/BUSY/DONE handshake so it can sit behind a sequencer or a slow operand source.

Parameters:
- SIZE, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits subtracted per cycle. NCH = SIZE/CHUNK cycles per operation; NCH >= 1.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  request; sampled only when state is IDLE or DONE.
- A  input  SIZE  minuend; captured on an accepted START.
- B  input  SIZE  subtrahend; captured on an accepted START.
- BIN  input  1  borrow-in; captured on an accepted START.
- BUSY  output  1  high while an operation is in progress (state RUN).
- DONE  output  1  one-cycle pulse; results are valid in this cycle and held afterwards.
- DIFF  output  SIZE  (A - B - BIN) mod 2^SIZE.
- BOUT  output  1  unsigned borrow-out: 1 iff A < B + BIN (unsigned).
- OVF  output  1  signed overflow: (A[msb] != B[msb]) && (DIFF[msb] != A[msb]).
- ZERO  output  1  1 iff DIFF == 0.

Behaviour:
- Reset values: RST high at an edge sets state IDLE and forces BUSY=0, DONE=0, DIFF=0, BOUT=0, OVF=0, ZERO=0, chunk counter=0, internal borrow=0.
  - RST has priority over START and over any operation in flight; a running operation is aborted and its result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: START=1 at edge k -> capture A, B, BIN into operand registers; borrow <= BIN; counter <= 0; go to RUN. BUSY=1 after edge k.
  - RUN: each edge processes chunk `cnt`, least-significant chunk first:
    - {b_out, d} = A_chunk - B_chunk - borrow, computed CHUNK+1 bits wide;
    - DIFF chunk <= d; borrow <= b_out; counter <= counter + 1.
    - After the edge that processes chunk NCH-1 (edge k+NCH), go to DONE. BOUT, OVF and ZERO are updated at that same edge.
  - DONE: DONE=1 and BUSY=0 for exactly this cycle.
    - START=1 -> accepted exactly as from IDLE (back-to-back operation, no bubble).
    - Otherwise -> IDLE.
- Latency: DONE is high in the cycle following edge k+NCH, i.e. NCH cycles after the START edge. Throughput is one operation per NCH+1 cycles (the DONE cycle accepts the next START).
- START while in RUN is ignored; it is not queued. Operand changes during RUN have no effect because operands are registered.
- DIFF/BOUT/OVF/ZERO hold their last completed values through IDLE until the next operation completes.
  - During RUN, DIFF chunks update progressively and are not valid until DONE.
- Width rules:
  - The counter is ceil(log2(NCH+1)) bits, minimum 1.
  - The borrow chain is CHUNK+1 bits wide per step; no sign extension is applied internally.
  - OVF uses the captured operand MSBs.
- NCH=1 (SIZE == CHUNK) is legal: RUN lasts one cycle.

Optional Feature:
- Macro: SEQ_SUBTRACTOR_ADD_MODE_EN.
- Defined: adds input port OP (1 bit), captured with the operands on an accepted START.
  - OP=1 performs A + B + BIN. BIN acts as carry-in, BOUT reports carry-out, and OVF = (A[msb] == B[msb]) && (DIFF[msb] != A[msb]).
  - OP=0 is identical to subtract mode. Latency is unchanged.
- Undefined: no OP port; the block is subtract-only as specified above.

Test Plan:
1. SIZE=32, CHUNK=8. A=0x00000005, B=0x00000003, BIN=0, START pulse -> BUSY for 4 cycles; DONE=1 in the 4th cycle after the START edge; DIFF=0x00000002, BOUT=0, OVF=0, ZERO=0.
2. Inter-chunk borrow and wrap:
   - A=0x00000100, B=0x00000001 -> DIFF=0x000000FF, BOUT=0.
   - Then A=0, B=1 -> DIFF=0xFFFFFFFF, BOUT=1, OVF=0.
3. Signed overflow / zero with BIN:
   - A=0x80000000, B=0x00000001 -> DIFF=0x7FFFFFFF, OVF=1, BOUT=0.
   - A=0x12345678, B=0x12345677, BIN=1 -> DIFF=0, ZERO=1, BOUT=0.
4. Handshake:
   - START held high through RUN with changing A/B -> ignored; result reflects the captured operands.
   - START asserted in the DONE cycle -> new op begins; its DONE follows 4 cycles later.
5. RST asserted for one cycle during the 2nd RUN cycle -> next cycle all outputs 0, state IDLE, no DONE pulse. A subsequent START produces a correct result.
6. With SEQ_SUBTRACTOR_ADD_MODE_EN defined: OP=1, A=0x7FFFFFFF, B=1, BIN=0 -> DIFF=0x80000000, OVF=1, BOUT=0. OP=1, A=0xFFFFFFFF, B=1 -> DIFF=0, BOUT=1, ZERO=1.

Source files
------------

// File: rtl/seq_subtractor.sv
// rtl/seq_subtractor.sv - chunk-serial A - B - BIN subtractor with START/BUSY/DONE handshake
// Optional: define SEQ_SUBTRACTOR_ADD_MODE_EN to add the OP port (OP=1 computes A + B + BIN).
module seq_subtractor #(
  parameter int SIZE  = 32,
  parameter int CHUNK = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic [SIZE-1:0] A,
  input  logic [SIZE-1:0] B,
  input  logic            BIN,
`ifdef SEQ_SUBTRACTOR_ADD_MODE_EN
  input  logic            OP,
`endif
  output logic            BUSY,
  output logic            DONE,
  output logic [SIZE-1:0] DIFF,
  output logic            BOUT,
  output logic            OVF,
  output logic            ZERO
);
  localparam int NCH = SIZE / CHUNK;
  localparam int CW  = (NCH + 1 <= 2) ? 1 : $clog2(NCH + 1);
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [SIZE-1:0]  a_q, b_q, diff_q, diff_nxt;
  logic             add_q, borrow, op_in, accept, last;
  logic             bout_q, ovf_q, zero_q, ovf_nxt;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] a_c, b_c;
  logic [CHUNK:0]   step;
  int               idx;

`ifdef SEQ_SUBTRACTOR_ADD_MODE_EN
  assign op_in = OP;
`else
  assign op_in = 1'b0;
`endif

  assign accept = START && (state != S_RUN);
  assign last   = (cnt == LAST);

  always_ff @(posedge CLK) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (START) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = START ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    BUSY = (state == S_RUN);
    DONE = (state == S_DONE);
  end

  // One chunk per cycle; the top bit of the CHUNK+1 wide step is the borrow (or carry) out.
  always_comb begin
    idx      = int'(cnt) * CHUNK;
    a_c      = a_q[idx +: CHUNK];
    b_c      = b_q[idx +: CHUNK];
    if (add_q) step = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, borrow};
    else       step = {1'b0, a_c} - {1'b0, b_c} - {{CHUNK{1'b0}}, borrow};
    diff_nxt = diff_q;
    diff_nxt[idx +: CHUNK] = step[CHUNK-1:0];
    if (add_q) ovf_nxt = (a_q[SIZE-1] == b_q[SIZE-1]) && (diff_nxt[SIZE-1] != a_q[SIZE-1]);
    else       ovf_nxt = (a_q[SIZE-1] != b_q[SIZE-1]) && (diff_nxt[SIZE-1] != a_q[SIZE-1]);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q    <= '0;
      b_q    <= '0;
      add_q  <= 1'b0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (accept) begin
      a_q    <= A;
      b_q    <= B;
      add_q  <= op_in;
      borrow <= BIN;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      diff_q <= diff_nxt;
      borrow <= step[CHUNK];
      cnt    <= cnt + 1'b1;
      if (last) begin
        bout_q <= step[CHUNK];
        ovf_q  <= ovf_nxt;
        zero_q <= (diff_nxt == '0);
      end
    end
  end

  assign DIFF = diff_q;
  assign BOUT = bout_q;
  assign OVF  = ovf_q;
  assign ZERO = zero_q;
endmodule

// File: tb/tb_seq_subtractor.sv
// tb/tb_seq_subtractor.sv - scoreboard bench for seq_subtractor with a plain-arithmetic reference model
// Add-mode cases are exercised when SEQ_SUBTRACTOR_ADD_MODE_EN is defined.
module tb_seq_subtractor;
  localparam int SIZE = 32;
  localparam int CHUNK = 8;
  localparam int NCH = SIZE / CHUNK;

  typedef struct {
    logic [31:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
    int          done_cyc;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST, START, BIN, op;
  logic [31:0] A, B;
  logic        BUSY, DONE, BOUT, OVF, ZERO;
  logic [31:0] DIFF;

  exp_t sb_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   busy_cnt = 0;

  seq_subtractor #(.SIZE(SIZE), .CHUNK(CHUNK)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .BIN(BIN),
`ifdef SEQ_SUBTRACTOR_ADD_MODE_EN
    .OP(op),
`endif
    .BUSY(BUSY), .DONE(DONE), .DIFF(DIFF), .BOUT(BOUT), .OVF(OVF), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic bin, input logic add);
    exp_t   m;
    longint ua, ub, sa, sb, ci, ur, sr;
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ci = longint'({63'b0, bin});
    if (add) begin
      ur     = ua + ub + ci;
      sr     = sa + sb + ci;
      m.bout = (ur > 64'h0000_0000_FFFF_FFFF);
    end else begin
      ur     = ua - ub - ci;
      sr     = sa - sb - ci;
      m.bout = (ua < ub + ci);
    end
    m.diff = ur[31:0];
    m.ovf  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    m.zero = (m.diff == 32'h0);
    m.done_cyc = 0;
    return m;
  endfunction

  // Monitor: pops an expectation whenever the DUT pulses DONE.
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      busy_cnt = 0;
    end else begin
      if (BUSY) busy_cnt++;
      if (DONE) begin
        check("busy_in_done", BUSY, 1'b0);
        check("busy_cycles", busy_cnt, NCH);
        busy_cnt = 0;
        if (sb_q.size() == 0) begin
          check("unexpected_done", DONE, 1'b0);
        end else begin
          e = sb_q.pop_front();
          check("diff", DIFF, e.diff);
          check("bout", BOUT, e.bout);
          check("ovf", OVF, e.ovf);
          check("zero", ZERO, e.zero);
          check("done_cycle", cyc, e.done_cyc);
        end
      end
    end
  end

  // Issues one op; returns in its DONE cycle with START low so the next call goes back-to-back.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic add, input logic hold);
    exp_t e;
    bit   seen;
    A = a; B = b; BIN = bin; op = add; START = 1'b1;
    @(posedge CLK); #1;
    e = model(a, b, bin, add);
    e.done_cyc = cyc + NCH;
    sb_q.push_back(e);
    START = hold;
    seen = 0;
    for (int i = 0; i < 4 * NCH + 8; i++) begin
      A = $urandom; B = $urandom; BIN = 1'($urandom); op = 1'($urandom);
      @(posedge CLK); #1;
      if (DONE) begin
        seen = 1;
        break;
      end
    end
    START = 1'b0;
    check("done_seen", seen, 1'b1);
    if (!seen && sb_q.size() > 0) void'(sb_q.pop_back());
  endtask

  task automatic idle(input int n);
    START = 1'b0;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_done"}, DONE, 1'b0);
    check({tag, "_diff"}, DIFF, 32'h0);
    check({tag, "_bout"}, BOUT, 1'b0);
    check({tag, "_ovf"}, OVF, 1'b0);
    check({tag, "_zero"}, ZERO, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    RST = 1'b1; START = 1'b0; A = '0; B = '0; BIN = 1'b0; op = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_reset_outputs("reset");
    RST = 1'b0;

    run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    idle(2);
    run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 1'b0, 1'b1);
    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 1'b1);

    // Abort an operation during its second RUN cycle.
    A = 32'h0000_0009; B = 32'h0000_0004; BIN = 1'b0; op = 1'b0; START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    check_reset_outputs("abort");
    RST = 1'b0;
    idle(NCH + 3);
    run_op(32'h0000_0009, 32'h0000_0004, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_SUBTRACTOR_ADD_MODE_EN
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b0);
`endif

    for (int i = 0; i < 150; i++) begin
      logic add;
`ifdef SEQ_SUBTRACTOR_ADD_MODE_EN
      add = 1'($urandom);
`else
      add = 1'b0;
`endif
      run_op(pick(), pick(), 1'($urandom), add, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end

    idle(2);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
